// File: rtl/hpm_counter_unit_pkg.sv
// Shared CSR addresses, limits and address/bit helpers for the HPM counter block.
package hpm_counter_unit_pkg;

    typedef logic [11:0] csr_addr_t;

    localparam int unsigned MAX_HPM = 29;

    localparam csr_addr_t CSR_ADDR_MCYCLE        = 12'hB00;
    localparam csr_addr_t CSR_ADDR_MINSTRET      = 12'hB02;
    localparam csr_addr_t CSR_ADDR_MCYCLEH       = 12'hB80;
    localparam csr_addr_t CSR_ADDR_MINSTRETH     = 12'hB82;
    localparam csr_addr_t CSR_ADDR_MCOUNTINHIBIT = 12'h320;
    localparam csr_addr_t CSR_ADDR_MHPMEVENT3    = 12'h323;
    localparam csr_addr_t CSR_ADDR_MHPMCOUNTER3  = 12'hB03;
    localparam csr_addr_t CSR_ADDR_MHPMCOUNTER3H = 12'hB83;
    localparam csr_addr_t CSR_ADDR_MHPMOVF       = 12'h7C0;

    // Counter slot k: 0 = mcycle, 1 = minstret, 2+i = mhpmcounter(3+i).
    function automatic csr_addr_t cnt_addr(input int unsigned k, input logic hi);
        csr_addr_t a;
        if (k == 0)      a = hi ? CSR_ADDR_MCYCLEH : CSR_ADDR_MCYCLE;
        else if (k == 1) a = hi ? CSR_ADDR_MINSTRETH : CSR_ADDR_MINSTRET;
        else             a = (hi ? CSR_ADDR_MHPMCOUNTER3H : CSR_ADDR_MHPMCOUNTER3) + 12'(k - 2);
        return a;
    endfunction

    // Position of counter slot k in mcountinhibit / mhpmovf.
    function automatic int unsigned cnt_bit(input int unsigned k);
        return (k == 0) ? 0 : (k == 1) ? 2 : k + 1;
    endfunction

    function automatic logic [31:0] inhibit_mask(input int unsigned n);
        logic [31:0] m;
        m = 32'h5;
        for (int unsigned i = 0; i < n; i++) m[3+i] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/hpm_counter_unit_if.sv
// CSR access bus between the core's CSR stage (master) and the counter block (slave).
interface hpm_counter_unit_if;
    import hpm_counter_unit_pkg::*;

    csr_addr_t   addr;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;

    modport master (output addr, rd_en, wr_en, wdata, input rdata, hit);
    modport slave  (input addr, rd_en, wr_en, wdata, output rdata, hit);
endinterface

// File: rtl/hpm_counter_unit_counter.sv
// One W-bit machine counter with half-word CSR writes; a write beats an increment.
module hpm_counter #(
    parameter int unsigned W = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         wr_lo_i,
    input  logic         wr_hi_i,
    input  logic [31:0]  wdata_i,
    output logic [W-1:0] value_o,
    output logic         wrap_o
);
    logic [W-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        wrap_o  = 1'b0;
        if (wr_lo_i) begin
            value_d = {value_q[W-1:32], wdata_i};
        end else if (wr_hi_i) begin
            // Truncation drops write bits above the implemented width.
            value_d = W'({wdata_i, value_q[31:0]});
        end else if (inc_i) begin
            value_d = value_q + W'(1);
            wrap_o  = &value_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) value_q <= '0;
        else       value_q <= value_d;
    end

    assign value_o = value_q;
endmodule

// File: rtl/hpm_counter_unit.sv
// mcycle/minstret/mhpmcounter block with event masks and mcountinhibit.
// HPM_OVERFLOW_IRQ_EN adds sticky wrap flags at mhpmovf and a registered overflow irq.
module hpm_counter_unit
    import hpm_counter_unit_pkg::*;
#(
    parameter int unsigned NUM_HPM   = 4,
    parameter int unsigned CNT_WIDTH = 64
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    hpm_counter_unit_if.slave                      csr_if,
    input  logic                                   instr_retire_i,
    input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event_i,
    output logic                                   ovf_irq_o
);
    localparam int unsigned NC = NUM_HPM + 2;
    localparam int unsigned EW = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam logic [31:0] INH_MASK = inhibit_mask(NUM_HPM);

    logic [NC-1:0]                inc, evt_hit, wr_lo, wr_hi, wrap;
    logic [NC-1:0][CNT_WIDTH-1:0] cnt_val;
    logic [NC-1:0][63:0]          cnt_wide;
    logic [EW-1:0][EW-1:0]        mask_q, mask_d;
    logic [EW-1:0]                wr_evt;
    logic [31:0]                  inh_q, inh_d;
    logic                         wr_inh, wr_ovf, owned;
    logic [31:0]                  rdata, ovf_rd;

    for (genvar k = 0; k < NC; k++) begin : g_cnt
        hpm_counter #(.W(CNT_WIDTH)) u_cnt (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .inc_i   (inc[k]),
            .wr_lo_i (wr_lo[k]),
            .wr_hi_i (wr_hi[k]),
            .wdata_i (csr_if.wdata),
            .value_o (cnt_val[k]),
            .wrap_o  (wrap[k])
        );
        assign cnt_wide[k] = 64'(cnt_val[k]);
    end

    // Increments use the inhibit value held before any write this cycle.
    always_comb begin
        evt_hit    = '0;
        inc        = '0;
        evt_hit[0] = 1'b1;
        evt_hit[1] = instr_retire_i;
        for (int i = 0; i < NUM_HPM; i++) evt_hit[2+i] = |(hpm_event_i & mask_q[i]);
        for (int k = 0; k < NC; k++) inc[k] = evt_hit[k] & ~inh_q[cnt_bit(k)];
    end

    always_comb begin
        owned  = 1'b0;
        rdata  = '0;
        wr_lo  = '0;
        wr_hi  = '0;
        wr_evt = '0;
        wr_inh = 1'b0;
        wr_ovf = 1'b0;
        for (int k = 0; k < NC; k++) begin
            if (csr_if.addr == cnt_addr(k, 1'b0)) begin
                owned    = 1'b1;
                rdata    = cnt_wide[k][31:0];
                wr_lo[k] = csr_if.wr_en;
            end
            if (csr_if.addr == cnt_addr(k, 1'b1)) begin
                owned    = 1'b1;
                rdata    = cnt_wide[k][63:32];
                wr_hi[k] = csr_if.wr_en;
            end
        end
        for (int i = 0; i < NUM_HPM; i++) begin
            if (csr_if.addr == CSR_ADDR_MHPMEVENT3 + 12'(i)) begin
                owned     = 1'b1;
                rdata     = 32'(mask_q[i]);
                wr_evt[i] = csr_if.wr_en;
            end
        end
        if (csr_if.addr == CSR_ADDR_MCOUNTINHIBIT) begin
            owned  = 1'b1;
            rdata  = inh_q;
            wr_inh = csr_if.wr_en;
        end
`ifdef HPM_OVERFLOW_IRQ_EN
        if (csr_if.addr == CSR_ADDR_MHPMOVF) begin
            owned  = 1'b1;
            rdata  = ovf_rd;
            wr_ovf = csr_if.wr_en;
        end
`endif
    end

    assign csr_if.hit   = owned & (csr_if.rd_en | csr_if.wr_en);
    assign csr_if.rdata = (owned & csr_if.rd_en) ? rdata : 32'h0;

    always_comb begin
        inh_d  = wr_inh ? (csr_if.wdata & INH_MASK) : inh_q;
        mask_d = mask_q;
        for (int i = 0; i < NUM_HPM; i++)
            if (wr_evt[i]) mask_d[i] = csr_if.wdata[EW-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inh_q  <= '0;
            mask_q <= '0;
        end else begin
            inh_q  <= inh_d;
            mask_q <= mask_d;
        end
    end

`ifdef HPM_OVERFLOW_IRQ_EN
    logic [31:0] ovf_q, ovf_d, ovf_set;
    logic        irq_q;

    // A wrap in the same cycle as a write-1-to-clear leaves the flag set.
    always_comb begin
        ovf_set = '0;
        for (int k = 0; k < NC; k++) ovf_set[cnt_bit(k)] = wrap[k];
        ovf_d = (ovf_q & ~(wr_ovf ? csr_if.wdata : 32'h0)) | ovf_set;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q <= '0;
            irq_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            irq_q <= |ovf_d;
        end
    end

    assign ovf_rd    = ovf_q;
    assign ovf_irq_o = irq_q;
`else
    logic unused_ovf;
    assign unused_ovf = ^{wrap, wr_ovf};
    assign ovf_rd     = '0;
    assign ovf_irq_o  = 1'b0;
`endif

endmodule
